// File: rtl/meter_pkg.sv
// Shared constants and types for the VU-meter chain (max stage, ballistics, LED driver).
package meter_pkg;

    localparam int DEF_WIDTH      = 6;
    localparam int DEF_DECAY_DIV  = 4;
    localparam int DEF_HOLD_COUNT = 32;
    localparam int DEF_FALL_DIV   = 2;

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        HOLD  = 2'd1,
        FALL  = 2'd2
    } peak_state_e;

    // Counter width for a modulo-n count; a one-state counter still needs one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/meter_strobe_div.sv
// Strobe-gated modulo-N counter; wrap_o flags the strobe on which the count rolls over.
module meter_strobe_div
    import meter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic strobe_i,
    output logic wrap_o
);

    localparam int CW = cntWidth(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (strobe_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap_o = strobe_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/meter_ballistics.sv
// Meter ballistics: instant attack, slow linear decay on level, plus a hold-then-fall peak marker.
// The peak marker is built only when METER_PEAK_HOLD_EN is defined; otherwise peak mirrors level.
module meter_ballistics
    import meter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DECAY_DIV  = DEF_DECAY_DIV,
    parameter int HOLD_COUNT = DEF_HOLD_COUNT,
    parameter int FALL_DIV   = DEF_FALL_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] peak,
    output logic             dout_valid
);

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] levelDec;
    logic             valid_q;
    logic             attack;
    logic             decayWrap;

    assign attack = din_valid && (din >= level_q);

    meter_strobe_div #(
        .N(DECAY_DIV)
    ) u_decay_div (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (attack),
        .strobe_i(din_valid && !attack),
        .wrap_o  (decayWrap)
    );

    // A decay step happens only when din < level, so level is at least 1 here.
    assign levelDec = level_q - 1'b1;

    always_comb begin
        level_d = level_q;
        if (attack) begin
            level_d = din;
        end else if (decayWrap) begin
            level_d = (levelDec > din) ? levelDec : din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= din_valid;
            level_q <= level_d;
        end
    end

    assign level      = level_q;
    assign dout_valid = valid_q;

`ifdef METER_PEAK_HOLD_EN
    localparam int HW = cntWidth(HOLD_COUNT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNT - 1);
    localparam logic [1:0] ST_TRACK = TRACK;
    localparam logic [1:0] ST_HOLD  = HOLD;
    localparam logic [1:0] ST_FALL  = FALL;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] peak_q;
    logic [WIDTH-1:0] peak_d;
    logic [WIDTH-1:0] peakStep;
    logic [HW-1:0]    hold_q;
    logic [HW-1:0]    hold_d;
    logic             trigger;
    logic             fallWrap;

    assign trigger = din_valid && (din >= peak_q);

    meter_strobe_div #(
        .N(FALL_DIV)
    ) u_fall_div (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (trigger),
        .strobe_i(din_valid && !trigger && (state_q == ST_FALL)),
        .wrap_o  (fallWrap)
    );

    assign peakStep = fallWrap ? peak_q - 1'b1 : peak_q;

    // Peak decisions compare against the freshly computed level so peak never dips below it.
    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        if (trigger) begin
            peak_d  = din;
            hold_d  = HOLD_LAST;
            state_d = ST_HOLD;
        end else if (din_valid) begin
            case (state_q)
                ST_TRACK: peak_d = level_d;
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        state_d = ST_FALL;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                ST_FALL: begin
                    if (peakStep <= level_d) begin
                        peak_d  = level_d;
                        state_d = ST_TRACK;
                    end else begin
                        peak_d = peakStep;
                    end
                end
                default: state_d = ST_TRACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_TRACK;
            peak_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = level_q;
`endif

endmodule

// File: tb/tb_meter_ballistics.sv
// Randomized self-checking bench for meter_ballistics (default build and DECAY_DIV=1 variant).
module tb_meter_ballistics;

    logic       clk;
    logic       rst;
    logic [5:0] din;
    logic       din_valid;
    logic [5:0] lvl0, pk0, lvl1, pk1;
    logic       vld0, vld1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int level;
        int sinceDecay;
        int peak;
        int mode;
        int holdLeft;
        int fallPhase;
    } model_t;

    model_t m0, m1;

    meter_ballistics dut0 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .level     (lvl0),
        .peak      (pk0),
        .dout_valid(vld0)
    );

    meter_ballistics #(
        .DECAY_DIV(1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .level     (lvl1),
        .peak      (pk1),
        .dout_valid(vld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t modelReset();
        model_t m;
        m.level = 0; m.sinceDecay = 0; m.peak = 0;
        m.mode = 0; m.holdLeft = 0; m.fallPhase = 0;
        return m;
    endfunction

    // Reference behaviour from the meter rules: mode 0=track, 1=hold, 2=fall.
    function automatic model_t modelStep(model_t m, int d, int decayDiv);
        int r;
        if (d >= m.level) begin
            m.level = d;
            m.sinceDecay = 0;
        end else begin
            m.sinceDecay++;
            if (m.sinceDecay == decayDiv) begin
                m.sinceDecay = 0;
                m.level = (m.level - 1 > d) ? m.level - 1 : d;
            end
        end
`ifdef METER_PEAK_HOLD_EN
        if (d >= m.peak) begin
            m.peak = d;
            m.holdLeft = 32 - 1;
            m.fallPhase = 0;
            m.mode = 1;
        end else if (m.mode == 0) begin
            m.peak = m.level;
        end else if (m.mode == 1) begin
            if (m.holdLeft == 0) m.mode = 2;
            else m.holdLeft--;
        end else begin
            r = m.peak;
            m.fallPhase++;
            if (m.fallPhase == 2) begin
                m.fallPhase = 0;
                r = m.peak - 1;
            end
            if (r <= m.level) begin
                m.peak = m.level;
                m.mode = 0;
            end else begin
                m.peak = r;
            end
        end
`else
        m.peak = m.level;
`endif
        return m;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int d, input bit v, input bit r);
        din       = d[5:0];
        din_valid = v;
        rst       = r;
        @(posedge clk);
        #1;
        if (r) begin
            m0 = modelReset();
            m1 = modelReset();
        end else if (v) begin
            m0 = modelStep(m0, d, 4);
            m1 = modelStep(m1, d, 1);
        end
        checkOutput("dout_valid0", int'(vld0), int'(v && !r));
        checkOutput("dout_valid1", int'(vld1), int'(v && !r));
        checkOutput("level0", int'(lvl0), m0.level);
        checkOutput("peak0", int'(pk0), m0.peak);
        checkOutput("level1", int'(lvl1), m1.level);
        checkOutput("peak1", int'(pk1), m1.peak);
        checkOutput("peak_ge_level0", int'(pk0 >= lvl0), 1);
        checkOutput("peak_ge_level1", int'(pk1 >= lvl1), 1);
    endtask

    initial begin
        int decayExp[8];
        int d;
        bit v;
        bit r;

        decayExp = '{40, 40, 40, 39, 39, 39, 39, 38};
        m0 = modelReset();
        m1 = modelReset();
        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;

        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("reset_level", int'(lvl0), 0);
        checkOutput("reset_peak", int'(pk0), 0);

        // Attack
        applyStimulus(40, 1, 0);
        checkOutput("attack_level", int'(lvl0), 40);
        checkOutput("attack_peak", int'(pk0), 40);
        applyStimulus(0, 0, 0);
        checkOutput("idle_level", int'(lvl0), 40);
        applyStimulus(50, 1, 0);
        checkOutput("attack2_level", int'(lvl0), 50);
        checkOutput("attack2_peak", int'(pk0), 50);

        // Decay
        applyStimulus(0, 0, 1);
        applyStimulus(40, 1, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0);
            checkOutput($sformatf("decay_level_%0d", i), int'(lvl0), decayExp[i]);
            checkOutput($sformatf("decay1_level_%0d", i), int'(lvl1), 39 - i);
        end
        for (int i = 0; i < 6; i++) applyStimulus(39, 1, 0);
        checkOutput("decay_floor", int'(lvl0), 39);

        // Peak hold and fall, with idle gaps mixed in
        applyStimulus(0, 0, 1);
        applyStimulus(63, 1, 0);
        for (int i = 0; i < 160; i++) applyStimulus(0, ($urandom_range(0, 3) != 0), 0);

        // Re-trigger during fall
        applyStimulus(0, 0, 1);
        applyStimulus(63, 1, 0);
        for (int i = 0; i < 200 && !(m0.mode == 2 && m0.peak <= 55); i++) applyStimulus(0, 1, 0);
        applyStimulus(60, 1, 0);
`ifdef METER_PEAK_HOLD_EN
        checkOutput("retrigger_peak", int'(pk0), 60);
`endif
        for (int i = 0; i < 50; i++) applyStimulus(0, 1, 0);

        // Reset coincident with a strobe
        applyStimulus(63, 1, 1);
        checkOutput("rst_strobe_level", int'(lvl0), 0);
        checkOutput("rst_strobe_peak", int'(pk0), 0);
        checkOutput("rst_strobe_valid", int'(vld0), 0);
        applyStimulus(40, 1, 0);
        checkOutput("post_rst_level", int'(lvl0), 40);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 7))
                0: d = 63;
                1: d = 0;
                default: d = $urandom_range(0, 63);
            endcase
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 199) == 0);
            applyStimulus(d, v, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
